// File: rtl/text_line_buffer.sv
// ---------------------------------------------------------------------------
// text_line_buffer
//
// Holds one line of up to MAX_LEN typed letters (5-bit codes, 1=A .. 26=Z)
// and, for every pixel, tells the downstream sprite renderer which letter and
// glyph cell origin cover the current hcount/vcount.
//
// Optional feature macro: CURSOR_BLINK_EN
//   Adds output cursor_out, an underline cursor shown in the cell just past
//   the last letter on the bottom three rows of the line. It blinks with the
//   MSB of a 5-bit frame counter.
//
// Ports
//   pixel_clk_in   in   pixel clock
//   rst_n_in       in   asynchronous reset, active low
//   char_valid_in  in   letter offered on char_in
//   char_in[4:0]   in   letter code (only 1..26 are stored)
//   char_ready_out out  push accepted when char_valid_in && char_ready_out
//   backspace_in   in   single-cycle pulse, delete last letter
//   clear_in       in   single-cycle pulse, erase whole line (MAX_LEN cycles)
//   hcount_in      in   current pixel column
//   vcount_in      in   current pixel row
//   letter_out     out  letter for renderer, 0 = blank
//   x_out          out  glyph cell left edge
//   y_out          out  glyph cell top edge
//   hcount_out     out  hcount_in delayed 2 cycles
//   vcount_out     out  vcount_in delayed 2 cycles
//   cursor_out     out  cursor pixel flag (CURSOR_BLINK_EN only)
//   length_out     out  number of stored letters
//   full_out       out  length_out == MAX_LEN
// ---------------------------------------------------------------------------
module text_line_buffer #(
    parameter int MAX_LEN = 8,
    parameter int CELL_W  = 38,
    parameter int CELL_H  = 45,
    parameter int X0      = 100,
    parameter int Y0      = 200
) (
    input  logic                           pixel_clk_in,
    input  logic                           rst_n_in,
    input  logic                           char_valid_in,
    input  logic [4:0]                     char_in,
    output logic                           char_ready_out,
    input  logic                           backspace_in,
    input  logic                           clear_in,
    input  logic [10:0]                    hcount_in,
    input  logic [9:0]                     vcount_in,
    output logic [4:0]                     letter_out,
    output logic [10:0]                    x_out,
    output logic [9:0]                     y_out,
    output logic [10:0]                    hcount_out,
    output logic [9:0]                     vcount_out,
`ifdef CURSOR_BLINK_EN
    output logic                           cursor_out,
`endif
    output logic [$clog2(MAX_LEN+1)-1:0]   length_out,
    output logic                           full_out
);

    localparam int LW = $clog2(MAX_LEN + 1);
    localparam int KW = $clog2(MAX_LEN);

    localparam logic [10:0] ROW_LO = 11'(Y0);
    localparam logic [10:0] ROW_HI = 11'(Y0 + CELL_H);

    typedef enum logic {S_IDLE = 1'b0, S_CLEARING = 1'b1} state_t;

    state_t          r_state;
    state_t          w_state_next;
    logic [KW-1:0]   r_wipe;
    logic            r_alive;      // low only until the first edge after reset
    logic [LW-1:0]   r_len;
    logic [4:0]      r_entry [MAX_LEN];

    logic            w_idle;
    logic            w_clearing;
    logic            w_ready;
    logic            w_full;
    logic            w_wipe_last;
    logic            w_clear_go;
    logic            w_store;
    logic            w_bksp;
    logic            w_code_ok;

    // -----------------------------------------------------------------------
    // Edit FSM: state register / next state / outputs
    // -----------------------------------------------------------------------
    always_ff @(posedge pixel_clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:     if (r_alive && clear_in) w_state_next = S_CLEARING;
            S_CLEARING: if (w_wipe_last)         w_state_next = S_IDLE;
            default:                             w_state_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_idle     = r_alive && (r_state == S_IDLE);
        w_clearing = (r_state == S_CLEARING);
        w_ready    = w_idle && !w_full && !backspace_in && !clear_in;
    end

    assign char_ready_out = w_ready;
    assign w_full         = (r_len == LW'(MAX_LEN));
    assign full_out       = w_full;
    assign length_out     = r_len;
    assign w_wipe_last    = (r_wipe == KW'(MAX_LEN - 1));
    assign w_clear_go     = w_idle && clear_in;
    assign w_code_ok      = (char_in != 5'd0) && (char_in <= 5'd26);
    // Invalid codes still complete the handshake but are not stored.
    assign w_store        = char_valid_in && w_ready && w_code_ok;
    assign w_bksp         = w_idle && !clear_in && backspace_in && (r_len != '0);

    always_ff @(posedge pixel_clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_alive <= 1'b0;
            r_wipe  <= '0;
            r_len   <= '0;
        end else begin
            r_alive <= 1'b1;
            if (w_clear_go) begin
                r_wipe <= '0;
            end else if (w_clearing) begin
                r_wipe <= r_wipe + KW'(1);
            end

            if (w_clearing && w_wipe_last) begin
                r_len <= '0;
            end else if (w_store) begin
                r_len <= r_len + LW'(1);
            end else if (w_bksp) begin
                r_len <= r_len - LW'(1);
            end
        end
    end

    // One register per stored letter; each decodes its own write conditions.
    generate
        for (genvar gi = 0; gi < MAX_LEN; gi++) begin : g_entry
            always_ff @(posedge pixel_clk_in or negedge rst_n_in) begin
                if (!rst_n_in) begin
                    r_entry[gi] <= 5'd0;
                end else if (w_clearing && (r_wipe == KW'(gi))) begin
                    r_entry[gi] <= 5'd0;
                end else if (w_store && (r_len == LW'(gi))) begin
                    r_entry[gi] <= char_in;
                end else if (w_bksp && (r_len == LW'(gi + 1))) begin
                    r_entry[gi] <= 5'd0;
                end
            end
        end
    endgenerate

    // -----------------------------------------------------------------------
    // Display stage 1: row test and parallel cell comparators
    // -----------------------------------------------------------------------
    logic [MAX_LEN-1:0] w_hit;
    logic [KW-1:0]      w_k;
    logic               w_in_cell;
    logic [10:0]        w_cell_x;
    logic               w_in_row;

    generate
        for (genvar gi = 0; gi < MAX_LEN; gi++) begin : g_cmp
            localparam logic [11:0] C_LO = 12'(X0 + gi * CELL_W);
            localparam logic [11:0] C_HI = 12'(X0 + (gi + 1) * CELL_W);
            assign w_hit[gi] = ({1'b0, hcount_in} >= C_LO) &&
                               ({1'b0, hcount_in} <  C_HI);
        end
    endgenerate

    // Cells are disjoint, so at most one hit bit is set.
    always_comb begin
        w_k       = '0;
        w_in_cell = 1'b0;
        w_cell_x  = 11'(X0);
        for (int i = 0; i < MAX_LEN; i++) begin
            if (w_hit[i]) begin
                w_k       = KW'(i);
                w_in_cell = 1'b1;
                w_cell_x  = 11'(X0 + i * CELL_W);
            end
        end
    end

    assign w_in_row = ({1'b0, vcount_in} >= ROW_LO) && ({1'b0, vcount_in} < ROW_HI);

    logic          r_s1_row;
    logic          r_s1_cell;
    logic [KW-1:0] r_s1_k;
    logic [10:0]   r_s1_x;
    logic [10:0]   r_s1_h;
    logic [9:0]    r_s1_v;

    always_ff @(posedge pixel_clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_s1_row  <= 1'b0;
            r_s1_cell <= 1'b0;
            r_s1_k    <= '0;
            r_s1_x    <= '0;
            r_s1_h    <= '0;
            r_s1_v    <= '0;
        end else begin
            r_s1_row  <= w_in_row;
            r_s1_cell <= w_in_cell;
            r_s1_k    <= w_k;
            r_s1_x    <= w_cell_x;
            r_s1_h    <= hcount_in;
            r_s1_v    <= vcount_in;
        end
    end

    // -----------------------------------------------------------------------
    // Display stage 2: letter lookup against the current buffer state
    // -----------------------------------------------------------------------
    logic [4:0]  w_sel;
    logic        w_vis;
    logic [4:0]  r_letter;
    logic [10:0] r_x;
    logic [9:0]  r_y;
    logic [10:0] r_h2;
    logic [9:0]  r_v2;

    always_comb begin
        w_sel = 5'd0;
        for (int i = 0; i < MAX_LEN; i++) begin
            if (r_s1_k == KW'(i)) w_sel = r_entry[i];
        end
    end

    assign w_vis = r_s1_row && r_s1_cell && (LW'(r_s1_k) < r_len);

    always_ff @(posedge pixel_clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_letter <= '0;
            r_x      <= '0;
            r_y      <= '0;
            r_h2     <= '0;
            r_v2     <= '0;
        end else begin
            r_letter <= w_vis ? w_sel : 5'd0;
            r_x      <= w_vis ? r_s1_x : 11'(X0);
            r_y      <= 10'(Y0);
            r_h2     <= r_s1_h;
            r_v2     <= r_s1_v;
        end
    end

    assign letter_out = r_letter;
    assign x_out      = r_x;
    assign y_out      = r_y;
    assign hcount_out = r_h2;
    assign vcount_out = r_v2;

`ifdef CURSOR_BLINK_EN
    // -----------------------------------------------------------------------
    // Blinking underline cursor in the first empty cell
    // -----------------------------------------------------------------------
    localparam logic [10:0] CUR_LO = 11'(Y0 + CELL_H - 3);

    logic       r_s1_crow;
    logic [4:0] r_frame;
    logic       r_cursor;

    always_ff @(posedge pixel_clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_s1_crow <= 1'b0;
            r_frame   <= '0;
            r_cursor  <= 1'b0;
        end else begin
            r_s1_crow <= ({1'b0, vcount_in} >= CUR_LO) && ({1'b0, vcount_in} < ROW_HI);
            if ((hcount_in == 11'd0) && (vcount_in == 10'd0)) begin
                r_frame <= r_frame + 5'd1;
            end
            r_cursor  <= !w_full && r_s1_cell && (LW'(r_s1_k) == r_len) &&
                         r_s1_crow && r_frame[4];
        end
    end

    assign cursor_out = r_cursor;
`endif

endmodule

// File: tb/tb_text_line_buffer.sv
module tb_text_line_buffer;

    logic        pixel_clk_in = 1'b0;
    logic        rst_n_in;
    logic        char_valid_in;
    logic [4:0]  char_in;
    logic        char_ready_out;
    logic        backspace_in;
    logic        clear_in;
    logic [10:0] hcount_in;
    logic [9:0]  vcount_in;
    logic [4:0]  letter_out;
    logic [10:0] x_out;
    logic [9:0]  y_out;
    logic [10:0] hcount_out;
    logic [9:0]  vcount_out;
    logic [3:0]  length_out;
    logic        full_out;
`ifdef CURSOR_BLINK_EN
    logic        cursor_out;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    always #5 pixel_clk_in = ~pixel_clk_in;

    text_line_buffer dut (
        .pixel_clk_in   (pixel_clk_in),
        .rst_n_in       (rst_n_in),
        .char_valid_in  (char_valid_in),
        .char_in        (char_in),
        .char_ready_out (char_ready_out),
        .backspace_in   (backspace_in),
        .clear_in       (clear_in),
        .hcount_in      (hcount_in),
        .vcount_in      (vcount_in),
        .letter_out     (letter_out),
        .x_out          (x_out),
        .y_out          (y_out),
        .hcount_out     (hcount_out),
        .vcount_out     (vcount_out),
`ifdef CURSOR_BLINK_EN
        .cursor_out     (cursor_out),
`endif
        .length_out     (length_out),
        .full_out       (full_out)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) begin
            $display("[TB] ok   %s = %0d", tag, obs);
        end else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge pixel_clk_in);
        #1;
    endtask

    task automatic push(input logic [4:0] code);
        char_valid_in = 1'b1;
        char_in       = code;
        tick();
        char_valid_in = 1'b0;
        $display("[TB] push code %0d -> length %0d", code, length_out);
    endtask

    task automatic bksp();
        backspace_in = 1'b1;
        tick();
        backspace_in = 1'b0;
        $display("[TB] backspace -> length %0d", length_out);
    endtask

    // Present a pixel and wait out the 2-cycle display latency.
    task automatic show(input logic [10:0] h, input logic [9:0] v);
        hcount_in = h;
        vcount_in = v;
        tick();
        tick();
    endtask

    initial begin
        rst_n_in      = 1'b0;
        char_valid_in = 1'b0;
        char_in       = 5'd0;
        backspace_in  = 1'b0;
        clear_in      = 1'b0;
        hcount_in     = 11'd1;
        vcount_in     = 10'd1;

        // ---------------- reset state ----------------
        #3;
        chk("rst_ready",  char_ready_out, 0);
        chk("rst_length", length_out, 0);
        chk("rst_letter", letter_out, 0);
        chk("rst_x",      x_out, 0);
        chk("rst_y",      y_out, 0);
        chk("rst_hout",   hcount_out, 0);
        tick();
        rst_n_in = 1'b1;
        #1;
        chk("ready_before_edge", char_ready_out, 0);
        tick();
        chk("ready_after_release", char_ready_out, 1);

        // ---------------- test 1: push 3,1,20 ----------------
        push(5'd3);
        push(5'd1);
        push(5'd20);
        chk("t1_length", length_out, 3);
        show(11'd143, 10'd210);
        chk("t1_letter_c1", letter_out, 1);
        chk("t1_x_c1",      x_out, 138);
        chk("t1_y_c1",      y_out, 200);
        chk("t1_hout",      hcount_out, 143);
        chk("t1_vout",      vcount_out, 210);
        show(11'd177, 10'd244);
        chk("t1_letter_c2", letter_out, 20);
        chk("t1_x_c2",      x_out, 176);
        show(11'd215, 10'd210);
        chk("t1_letter_c3", letter_out, 0);
        chk("t1_x_c3",      x_out, 100);
        show(11'd99, 10'd210);
        chk("t1_left_of_x0", letter_out, 0);
        show(11'd100, 10'd245);
        chk("t1_below_row", letter_out, 0);
        show(11'd100, 10'd200);
        chk("t1_c0_top", letter_out, 3);

        // ---------------- test 4: backspace ----------------
        bksp();
        chk("t4_length2", length_out, 2);
        backspace_in  = 1'b1;
        char_valid_in = 1'b1;
        char_in       = 5'd7;
        #1;
        chk("t4_ready_bksp", char_ready_out, 0);
        tick();
        backspace_in  = 1'b0;
        char_valid_in = 1'b0;
        chk("t4_length1", length_out, 1);
        show(11'd143, 10'd210);
        chk("t4_entry1_zero", letter_out, 0);
        show(11'd101, 10'd210);
        chk("t4_entry0_kept", letter_out, 3);
        bksp();
        chk("t4_length0", length_out, 0);
        bksp();
        chk("t4_bksp_empty", length_out, 0);

        // ---------------- test 3: invalid codes ----------------
        char_valid_in = 1'b1;
        char_in       = 5'd0;
        #1;
        chk("t3_ready_code0", char_ready_out, 1);
        tick();
        char_in = 5'd29;
        #1;
        chk("t3_ready_code29", char_ready_out, 1);
        tick();
        char_valid_in = 1'b0;
        chk("t3_length", length_out, 0);
        show(11'd101, 10'd210);
        chk("t3_no_store", letter_out, 0);

        // ---------------- test 2: fill to full ----------------
        for (int i = 0; i < 8; i++) push(5'(10 + i));
        chk("t2_length8", length_out, 8);
        chk("t2_full",    full_out, 1);
        char_valid_in = 1'b1;
        char_in       = 5'd26;
        #1;
        chk("t2_ready_full", char_ready_out, 0);
        tick();
        char_valid_in = 1'b0;
        chk("t2_length_stay", length_out, 8);
        show(11'd368, 10'd210);
        chk("t2_entry7", letter_out, 17);
        chk("t2_x7",     x_out, 366);
        show(11'd403, 10'd210);
        chk("t2_last_px", letter_out, 17);
        show(11'd404, 10'd210);
        chk("t2_past_end", letter_out, 0);
        chk("t2_past_end_x", x_out, 100);

        // ---------------- test 5: clear ----------------
        bksp();
        bksp();
        bksp();
        chk("t5_length5", length_out, 5);
        chk("t5_not_full", full_out, 0);
        show(11'd253, 10'd210);
        chk("t5_entry4", letter_out, 14);
        clear_in = 1'b1;
        #1;
        chk("t5_ready_clrpulse", char_ready_out, 0);
        tick();
        clear_in = 1'b0;
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("t5_ready_clr%0d", i), char_ready_out, 0);
            chk($sformatf("t5_len_clr%0d", i), length_out, 5);
            tick();
        end
        chk("t5_ready_done", char_ready_out, 1);
        chk("t5_length_done", length_out, 0);
        show(11'd101, 10'd210);
        chk("t5_cell0_blank", letter_out, 0);
        show(11'd253, 10'd210);
        chk("t5_cell4_blank", letter_out, 0);

        // reset during a clear
        push(5'd5);
        push(5'd6);
        show(11'd143, 10'd210);
        chk("t5_pre_letter", letter_out, 6);
        clear_in = 1'b1;
        tick();
        clear_in = 1'b0;
        tick();
        tick();
        #2;
        rst_n_in = 1'b0;
        #1;
        chk("t5_arst_length", length_out, 0);
        chk("t5_arst_ready",  char_ready_out, 0);
        chk("t5_arst_letter", letter_out, 0);
        chk("t5_arst_hout",   hcount_out, 0);
        chk("t5_arst_x",      x_out, 0);
        tick();
        rst_n_in = 1'b1;
        tick();
        chk("t5_ready_recover", char_ready_out, 1);
        push(5'd9);
        show(11'd101, 10'd210);
        chk("t5_recover_c0", letter_out, 9);
        show(11'd143, 10'd210);
        chk("t5_recover_c1", letter_out, 0);

`ifdef CURSOR_BLINK_EN
        // ---------------- test 6: cursor ----------------
        hcount_in = 11'd1;
        vcount_in = 10'd1;
        rst_n_in  = 1'b0;
        tick();
        rst_n_in = 1'b1;
        tick();
        push(5'd4);
        push(5'd5);
        show(11'd180, 10'd243);
        chk("t6_cursor_frame0", cursor_out, 0);
        hcount_in = 11'd0;
        vcount_in = 10'd0;
        repeat (16) tick();
        show(11'd180, 10'd243);
        chk("t6_cursor_on", cursor_out, 1);
        chk("t6_cursor_letter", letter_out, 0);
        show(11'd180, 10'd210);
        chk("t6_cursor_row", cursor_out, 0);
        show(11'd142, 10'd243);
        chk("t6_cursor_other_cell", cursor_out, 0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
